// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 32-bit to 16-bit asynchronous SRAM bridge.
package sram_controller_pkg;

  localparam int          SRAM_ADDR_W       = 18;
  localparam int          SRAM_DATA_W       = 16;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} sramStateT;

  // Half-word index of the low half of a word; wraps silently past the SRAM size.
  function automatic logic [SRAM_ADDR_W-1:0] halfWordAddr(input logic [31:0] byteAddr,
                                                          input logic [31:0] baseAddr);
    return SRAM_ADDR_W'(((byteAddr - baseAddr) >> 1) & ~32'd1);
  endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Phase timer: counts 0..ACCESS_CYCLES-1 and flags the last cycle of a phase.
module sram_phase_counter #(
  parameter  int ACCESS_CYCLES = 2,
  localparam int CW            = $clog2(ACCESS_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic [CW-1:0] loadValue,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  assign terminal = (count == CW'(ACCESS_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        count <= '0;
    else if (clear)  count <= '0;
    else if (load)   count <= loadValue;
    else if (enable) count <= count + 1'b1;
  end

endmodule

// File: rtl/sram_controller.sv
// Splits MEM-stage word loads/stores into two half-word accesses on an async SRAM;
// ready is low while an access is in flight and the top level freezes the pipeline on it.
//
// state | meaning
// IDLE  | waiting for rdEn/wrEn, SRAM bus released
// LOW   | half-word 0 of the word (writeData[15:0] / readData[15:0])
// HIGH  | half-word 1 of the word (writeData[31:16] / readData[31:16])
// DONE  | one-cycle completion, ready high so the pipeline advances
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEFAULT,
  parameter int          ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdEn,
  input  logic                   wrEn,
  input  logic [31:0]            address,
  input  logic [31:0]            writeData,
  output logic [31:0]            readData,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sramAddr,
  inout  wire  [SRAM_DATA_W-1:0] sramDq,
  output logic                   sramWeN
);

  localparam int CW = $clog2(ACCESS_CYCLES);

  sramStateT              state;
  logic                   isWrite;
  logic [31:0]            wrDataQ;
  logic [CW-1:0]          phaseCount;
  logic                   phaseLast;
  logic                   phaseHold;
  logic                   inPhase;
  logic                   dqOe;
  logic [SRAM_DATA_W-1:0] dqOut;

  assign inPhase   = (state == LOW) || (state == HIGH);
  assign phaseHold = (phaseCount == CW'(ACCESS_CYCLES - 2));
  assign ready     = ((state == IDLE) && !rdEn && !wrEn) || (state == DONE);

  sram_phase_counter #(.ACCESS_CYCLES(ACCESS_CYCLES)) uPhaseCounter (
    .clk       (clk),
    .rst       (rst),
    .clear     (!inPhase || phaseLast),
    .load      (1'b0),
    .loadValue ('0),
    .enable    (inPhase),
    .count     (phaseCount),
    .terminal  (phaseLast)
  );

  // Bus is decoded from registered state so an async reset releases it at once.
  assign dqOe   = isWrite && inPhase;
  assign dqOut  = (state == HIGH) ? wrDataQ[31:16] : wrDataQ[15:0];
  assign sramDq = dqOe ? dqOut : {SRAM_DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      isWrite  <= 1'b0;
      wrDataQ  <= '0;
      sramAddr <= '0;
      sramWeN  <= 1'b1;
      readData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rdEn || wrEn) begin
            state    <= LOW;
            isWrite  <= wrEn;
            wrDataQ  <= writeData;
            sramAddr <= halfWordAddr(address, BASE_ADDR);
            sramWeN  <= !wrEn;
          end
        end
        LOW: begin
          if (phaseLast) begin
            state       <= HIGH;
            sramAddr[0] <= 1'b1;
            sramWeN     <= !isWrite;
            if (!isWrite) readData[15:0] <= sramDq;
          end else if (phaseHold) begin
            sramWeN <= 1'b1;
          end
        end
        HIGH: begin
          if (phaseLast) begin
            state   <= DONE;
            sramWeN <= 1'b1;
            if (!isWrite) readData[31:16] <= sramDq;
          end else if (phaseHold) begin
            sramWeN <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (ACCESS_CYCLES 2 and 3) on behavioural SRAM models.
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rdEn, wrEn, useDut3, modelRd;
  logic [31:0] address, writeData;
  logic        rd2, wr2, rd3, wr3;
  logic [31:0] readData2, readData3;
  logic        ready2, ready3, weN2, weN3;
  logic [17:0] sramAddr2, sramAddr3;
  wire  [15:0] bus2, bus3;

  logic [15:0] mem2 [0:255];
  logic [15:0] mem3 [0:255];
  logic [15:0] refMem2 [0:255];
  logic [15:0] refMem3 [0:255];

  assign rd2 = rdEn & ~useDut3;
  assign wr2 = wrEn & ~useDut3;
  assign rd3 = rdEn & useDut3;
  assign wr3 = wrEn & useDut3;

  sram_controller dut (
    .clk(clk), .rst(rst), .rdEn(rd2), .wrEn(wr2), .address(address), .writeData(writeData),
    .readData(readData2), .ready(ready2), .sramAddr(sramAddr2), .sramDq(bus2), .sramWeN(weN2)
  );

  sram_controller #(.ACCESS_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .rdEn(rd3), .wrEn(wr3), .address(address), .writeData(writeData),
    .readData(readData3), .ready(ready3), .sramAddr(sramAddr3), .sramDq(bus3), .sramWeN(weN3)
  );

  // SRAM models: drive on reads, store while WE# is low, preset while reset is held.
  assign bus2 = (weN2 && modelRd && !useDut3) ? mem2[sramAddr2[7:0]] : 16'hzzzz;
  assign bus3 = (weN3 && modelRd && useDut3)  ? mem3[sramAddr3[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!rst) begin
      mem2[2] <= 16'h1234;
      mem2[3] <= 16'hABCD;
    end else if (!weN2) begin
      mem2[sramAddr2[7:0]] <= bus2;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      mem3[0] <= 16'h5555;
      mem3[1] <= 16'hAAAA;
    end else if (!weN3) begin
      mem3[sramAddr3[7:0]] <= bus3;
    end
  end

  logic        obsReady, obsWeN, obsOe;
  logic [31:0] obsRd;
  logic [17:0] obsAddr;
  logic [15:0] obsBus;
  assign obsReady = useDut3 ? ready3 : ready2;
  assign obsWeN   = useDut3 ? weN3 : weN2;
  assign obsOe    = useDut3 ? dut3.dqOe : dut.dqOe;
  assign obsRd    = useDut3 ? readData3 : readData2;
  assign obsAddr  = useDut3 ? sramAddr3 : sramAddr2;
  assign obsBus   = useDut3 ? bus3 : bus2;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] expLo;
  } vecT;

  typedef struct {
    logic        sel;
    logic [31:0] data;
  } sbT;

  vecT         vecs [11];
  sbT          sbQ [$];
  logic [31:0] lastRead2, lastRead3;
  int          checks, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic sbPop();
    sbT e;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_underflow at %0t: got completion expected none pending", $time);
    end else begin
      e = sbQ.pop_front();
      chk("readData", e.sel ? readData3 : readData2, e.data);
    end
  endtask

  // Call at posedge+1 with the selected DUT in IDLE; returns during the DONE cycle.
  task automatic runAccess(input vecT v);
    int          a, p;
    logic        wr, hiPh;
    logic [7:0]  lo;
    sbT          e;
    a = v.sel ? 3 : 2;
    wr = v.wr;
    lo = v.expLo[7:0];
    useDut3 = v.sel;
    modelRd = !wr;
    rdEn = v.rd; wrEn = v.wr; address = v.addr; writeData = v.wdata;
    e.sel = v.sel;
    if (wr) begin
      e.data = v.sel ? lastRead3 : lastRead2;
      if (v.sel) begin refMem3[lo] = v.wdata[15:0]; refMem3[lo + 8'd1] = v.wdata[31:16]; end
      else       begin refMem2[lo] = v.wdata[15:0]; refMem2[lo + 8'd1] = v.wdata[31:16]; end
    end else begin
      e.data = v.sel ? {refMem3[lo + 8'd1], refMem3[lo]} : {refMem2[lo + 8'd1], refMem2[lo]};
      if (v.sel) lastRead3 = e.data; else lastRead2 = e.data;
    end
    sbQ.push_back(e);
    #1 chk("ready_req_cycle", 32'(obsReady), 32'd0);
    for (int c = 1; c <= 2 * a + 1; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin address = ~v.addr; writeData = ~v.wdata; end
      #1;
      if (obsReady) sbPop();
      if (c <= 2 * a) begin
        hiPh = (c > a);
        p = hiPh ? c - a - 1 : c - 1;
        chk("ready_busy", 32'(obsReady), 32'd0);
        chk("sramAddr_phase", 32'(obsAddr), 32'({v.expLo[17:1], hiPh}));
        chk("sramWeN_phase", 32'(obsWeN), wr ? 32'(p == a - 1) : 32'd1);
        chk("dq_drive_phase", 32'(obsOe), 32'(wr));
        if (wr) chk("dq_data", 32'(obsBus), hiPh ? 32'(v.wdata[31:16]) : 32'(v.wdata[15:0]));
      end else begin
        chk("ready_done", 32'(obsReady), 32'd1);
        chk("sramWeN_done", 32'(obsWeN), 32'd1);
        chk("dq_drive_done", 32'(obsOe), 32'd0);
        chk("sramAddr_hold", 32'(obsAddr), 32'({v.expLo[17:1], 1'b1}));
      end
    end
  endtask

  initial begin
    vecT tail;
    rst = 1'b0; rdEn = 1'b0; wrEn = 1'b0; address = '0; writeData = '0;
    useDut3 = 1'b0; modelRd = 1'b0; checks = 0; errors = 0;
    lastRead2 = '0; lastRead3 = '0;
    for (int i = 0; i < 256; i++) begin refMem2[i] = '0; refMem3[i] = '0; end
    refMem2[2] = 16'h1234; refMem2[3] = 16'hABCD;
    refMem3[0] = 16'h5555; refMem3[1] = 16'hAAAA;

    //          rd    wr    sel   addr     wdata          expLo
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'd1028, 32'h0,        18'd2};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 18'd2};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'd1028, 32'h0,        18'd2};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 18'd4};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'd1032, 32'h0,        18'd4};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'd1022, 32'h12345678, 18'h3FFFE};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'd1022, 32'h0,        18'h3FFFE};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'd1024, 32'h0,        18'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'd1024, 32'h0BADC0DE, 18'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'd1024, 32'h0,        18'd0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 32'd1024, 32'h600DF00D, 18'd0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready2", 32'(ready2), 32'd1);
    chk("rst_ready3", 32'(ready3), 32'd1);
    chk("rst_weN2", 32'(weN2), 32'd1);
    chk("rst_weN3", 32'(weN3), 32'd1);
    chk("rst_dq2", 32'(dut.dqOe), 32'd0);
    chk("rst_readData2", readData2, 32'd0);
    chk("rst_readData3", readData3, 32'd0);
    chk("rst_sramAddr2", 32'(sramAddr2), 32'd0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      chk("idle_ready", 32'(ready2), 32'd1);
      chk("idle_weN", 32'(weN2), 32'd1);
      chk("idle_dq", 32'(dut.dqOe), 32'd0);
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      runAccess(vecs[i]);
      @(posedge clk);
      #1;
    end

    // Reset in the first HIGH cycle of a write on the 2-cycle instance.
    useDut3 = 1'b0; modelRd = 1'b0; rdEn = 1'b0; wrEn = 1'b1;
    address = 32'd1036; writeData = 32'h11112222;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_weN", 32'(weN2), 32'd0);
    chk("pre_rst_dq", 32'(dut.dqOe), 32'd1);
    chk("pre_rst_bus", 32'(bus2), 32'h1111);
    rst = 1'b0;
    #1;
    chk("mid_rst_weN", 32'(weN2), 32'd1);
    chk("mid_rst_dq", 32'(dut.dqOe), 32'd0);
    chk("mid_rst_readData", readData2, 32'd0);
    chk("mid_rst_sramAddr", 32'(sramAddr2), 32'd0);
    wrEn = 1'b0;
    #1 chk("mid_rst_ready", 32'(ready2), 32'd1);
    lastRead2 = '0;
    refMem2[2] = 16'h1234; refMem2[3] = 16'hABCD;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #2;
    chk("post_rst_ready", 32'(ready2), 32'd1);
    chk("post_rst_weN", 32'(weN2), 32'd1);
    @(posedge clk);
    #1;
    tail = '{1'b1, 1'b0, 1'b0, 32'd1022, 32'h0, 18'h3FFFE};
    runAccess(tail);
    @(posedge clk);
    #1;
    rdEn = 1'b0; wrEn = 1'b0;
    chk("sb_empty", 32'(sbQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Bridges the MEM stage's 32-bit load/store requests to an external 16-bit asynchronous SRAM. Each word is split into two half-word accesses. While an access is in flight, `ready` is held low; the top level inverts it into the `freeze` that stalls the pipeline registers, including the ID/EX register. This block is the producer end of the freeze/stall interface those registers consume.

## Interface
- `BASE_ADDR`, default 1024: byte address that maps to SRAM half-word 0.
- `ACCESS_CYCLES`, default 2: cycles spent on each half-word phase; must be ≥2.
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  reset; **asynchronous, active-low**.
- `rdEn`  input  1  load request from MEM stage.
- `wrEn`  input  1  store request from MEM stage.
- `address`  input  32  byte address, word-aligned.
- `writeData`  input  32  store data.
- `readData`  output  32  load result.
- `ready`  output  1  high when no access is pending; the top level drives freeze = ~ready.
- `sramAddr`  output  18  SRAM half-word address.
- `sramDq`  inout  16  SRAM data bus.
- `sramWeN`  output  1  SRAM write enable, active-low.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE. A phase counter counts from 0 to ACCESS_CYCLES-1 in LOW and in HIGH.
- **IDLE → LOW:** taken when `rdEn|wrEn`. On that edge the controller latches the operation, `address` and `writeData`.
  - If both enables are high, the write wins. This case is illegal for the pipeline but still defined.
- **LOW → HIGH → DONE:** each transition occurs when the counter reaches ACCESS_CYCLES-1.
- **DONE → IDLE:** always, after one cycle.
- `ready` is combinational: `ready = (IDLE & ~rdEn & ~wrEn) | DONE`.
  - It drops in the same cycle the request appears.
  - It returns high for exactly the DONE cycle, which is when the pipeline advances.
- **Address mapping:** `h = (address - BASE_ADDR) >> 1`, with bit 0 forced to 0.
  - `sramAddr = h[17:0]` in LOW and `h[17:0] | 1` in HIGH.
  - `sramAddr` is registered and updated on entry to each phase. It holds its value in IDLE and DONE.
  - Higher bits are truncated; wrap-around is silent.
- **Write:**
  - `sramDq` carries `writeData[15:0]` throughout LOW and `writeData[31:16]` throughout HIGH.
  - `sramWeN` is 0 for the first ACCESS_CYCLES-1 cycles of each phase and 1 in the last cycle of each phase, giving a data hold interval.
- **Read:**
  - `sramDq` is high-Z and `sramWeN` is 1.
  - `readData[15:0]` is captured on the last LOW cycle and `readData[31:16]` on the last HIGH cycle.
- `readData` holds its value until the next read overwrites it. Writes leave it unchanged.
- `sramDq` is high-Z in IDLE, in DONE, and for all reads.
- Enables or address changing after latching are ignored until IDLE is re-entered.

## Timing
- **Reset values:** state IDLE, counter 0, `readData` 0, `sramAddr` 0, `sramWeN` 1, `sramDq` high-Z. `ready` is 1 if no request is present.
- **Reset mid-access:** the access is aborted immediately and asynchronously. `sramWeN` goes to 1 and the bus to Z. No partial `readData` update survives.
- **Latency:** with the request present at cycle 0, LOW occupies cycles 1..A and HIGH occupies A+1..2A. DONE (`ready`=1) is cycle 2A+1, where A = ACCESS_CYCLES.
  - At the default, a stall is 5 cycles and DONE is cycle 5.
- **Back-to-back:** a request present in the cycle after DONE restarts the sequence with no extra bubble.
- **No request:** the controller stays in IDLE with `ready`=1 and no SRAM activity.

## Structure
- Shared package holds:
  - the state enum (IDLE/LOW/HIGH/DONE);
  - the SRAM address width (18) and data width (16) constants;
  - the `BASE_ADDR` default.
- One sub-module, `sram_phase_counter`: a loadable up-counter with clear and a terminal-count output, parameterised by ACCESS_CYCLES.
- Tri-state drive of `sramDq` stays in the top of this block.

## Test plan
- **Reset idle:** `rst`=0, then release with no requests → `ready`=1, `sramWeN`=1, `sramDq`=Z, `readData`=0.
- **Store:** `wrEn` with `address`=1028, `writeData`=0xDEADBEEF.
  - `ready`=0 for cycles 0–4 and 1 at cycle 5.
  - LOW phase: `sramAddr`=2, `sramDq`=0xBEEF.
  - HIGH phase: `sramAddr`=3, `sramDq`=0xDEAD.
  - `sramWeN` pulses low exactly one cycle per phase.
- **Load:** SRAM model holds 0x1234 at 2 and 0xABCD at 3; issue `rdEn` with `address`=1028.
  - At DONE, `readData`=0xABCD1234.
  - `sramWeN` stays 1 and the bus is never driven by the DUT.
- **Back-to-back and collision:** a load immediately after a store completes in 6 cycles with no bubble. `rdEn` and `wrEn` asserted together → a write is performed.
- **Reset mid-access:** assert `rst` during HIGH of a write → `sramWeN`=1 and bus Z immediately. After release, `ready`=1 and the FSM is in IDLE.
- **Parameter:** with ACCESS_CYCLES=3, a load reaches DONE at cycle 7; `address`=1024 maps to `sramAddr` 0/1.
